sevenseg_capture: RTL and testbench

SEVENSEG_CAPTURE -- requirements
Module: sevenseg_capture

---
 rtl/sevenseg_pkg.sv | 39 +++
 rtl/sevenseg_dec.sv | 29 ++
 rtl/sevenseg_capture.sv | 157 +++++++++++++++
 tb/tb_sevenseg_capture.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared seven-segment constants (active-low, seg[6:0] = a b c d e f g) and digit-enable helpers.
package sevenseg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] NIB_BLANK = 4'hF;

  typedef struct packed {
    logic       one;
    logic [1:0] idx;
  } an_sel_t;

  // Exactly one active-low enable -> its digit index; anything else flags one = 0.
  function automatic an_sel_t an_select(logic [3:0] an);
    an_sel_t s;
    s = '{one: 1'b0, idx: 2'd0};
    case (an)
      4'b1110: s = '{one: 1'b1, idx: 2'd0};
      4'b1101: s = '{one: 1'b1, idx: 2'd1};
      4'b1011: s = '{one: 1'b1, idx: 2'd2};
      4'b0111: s = '{one: 1'b1, idx: 2'd3};
      default: s = '{one: 1'b0, idx: 2'd0};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sevenseg_dec.sv
// Combinational seven-segment pattern to nibble decoder; blank decodes to 4'hF.
module sevenseg_dec
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nib,
  output logic       valid
);

  always_comb begin
    nib   = NIB_BLANK;
    valid = 1'b1;
    case (seg)
      SEG_0:     nib = 4'd0;
      SEG_1:     nib = 4'd1;
      SEG_2:     nib = 4'd2;
      SEG_3:     nib = 4'd3;
      SEG_4:     nib = 4'd4;
      SEG_5:     nib = 4'd5;
      SEG_6:     nib = 4'd6;
      SEG_7:     nib = 4'd7;
      SEG_8:     nib = 4'd8;
      SEG_9:     nib = 4'd9;
      SEG_BLANK: nib = NIB_BLANK;
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_capture.sv
// Monitors a multiplexed seven-segment display and captures each digit after a stable run.
// Optional error counting on malformed samples is enabled with SEVENSEG_CAPTURE_ERR_EN.
//
// state  | meaning
// IDLE   | no candidate sample (blank scan or malformed)
// TRACK  | counting consecutive identical candidate samples
// LOCKED | current candidate accepted, holding without rewrites
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] an,
  input  logic [6:0] seg,
  output logic [3:0] q3,
  output logic [3:0] q2,
  output logic [3:0] q1,
  output logic [3:0] q0,
  output logic [3:0] upd,
  output logic       frame
`ifdef SEVENSEG_CAPTURE_ERR_EN
  ,
  output logic       err,
  output logic [7:0] err_cnt
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] TRACK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] CNT_SAT  = 8'(STABLE_CYCLES);

  logic [3:0]                 an_s;
  logic [6:0]                 seg_s;
  logic [3:0]                 dec_nib;
  logic                       dec_valid;
  an_sel_t                    sel;
  logic                       cand;
  logic                       same;
  logic [1:0]                 state;
  logic [7:0]                 cnt;
  logic [1:0]                 trk_idx;
  logic [3:0]                 trk_nib;
  logic [1:0]                 last_idx;
  logic [NUM_DIGITS-1:0][3:0] q_r;

  sevenseg_dec u_dec (
    .seg   (seg_s),
    .nib   (dec_nib),
    .valid (dec_valid)
  );

  always_comb begin
    sel  = an_select(an_s);
    cand = sel.one & dec_valid;
    same = cand && (sel.idx == trk_idx) && (dec_nib == trk_nib);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_s     <= 4'hF;
      seg_s    <= SEG_BLANK;
      state    <= IDLE;
      cnt      <= 8'd0;
      trk_idx  <= 2'd0;
      trk_nib  <= NIB_BLANK;
      last_idx <= 2'd0;
      q_r      <= {NUM_DIGITS{NIB_BLANK}};
      upd      <= 4'd0;
      frame    <= 1'b0;
    end else begin
      an_s  <= an;
      seg_s <= seg;
      upd   <= 4'd0;
      frame <= 1'b0;
      case (state)
        IDLE: begin
          if (cand) begin
            state   <= TRACK;
            cnt     <= 8'd1;
            trk_idx <= sel.idx;
            trk_nib <= dec_nib;
          end
        end
        TRACK: begin
          if (!cand) begin
            state <= IDLE;
            cnt   <= 8'd0;
          end else if (same) begin
            if (cnt >= CNT_LAST) begin
              // This sample completes the run: accept and saturate the count.
              q_r[trk_idx] <= trk_nib;
              upd[trk_idx] <= 1'b1;
              frame        <= (trk_idx == 2'd0) && (last_idx != 2'd0);
              last_idx     <= trk_idx;
              cnt          <= CNT_SAT;
              state        <= LOCKED;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end else begin
            cnt     <= 8'd1;
            trk_idx <= sel.idx;
            trk_nib <= dec_nib;
          end
        end
        LOCKED: begin
          if (!cand) begin
            state <= IDLE;
            cnt   <= 8'd0;
          end else if (!same) begin
            state   <= TRACK;
            cnt     <= 8'd1;
            trk_idx <= sel.idx;
            trk_nib <= dec_nib;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

  assign q0 = q_r[0];
  assign q1 = q_r[1];
  assign q2 = q_r[2];
  assign q3 = q_r[3];

`ifdef SEVENSEG_CAPTURE_ERR_EN
  logic bad_s;
  logic bad_prev;

  assign bad_s = !cand && (an_s != 4'hF);

  // Count only the entry into a malformed run, not every cycle of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad_prev <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= 8'd0;
    end else begin
      bad_prev <= bad_s;
      if (bad_s && !bad_prev) begin
        err <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed bench for sevenseg_capture with a scoreboard of expected digit writes.
module tb_sevenseg_capture;
  import sevenseg_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] an;
  logic [6:0] seg;
  logic [3:0] q3, q2, q1, q0;
  logic [3:0] upd;
  logic       frame;
`ifdef SEVENSEG_CAPTURE_ERR_EN
  logic       err;
  logic [7:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         idx;
    logic [3:0] nib;
    logic       frm;
    int         at;
  } exp_t;

  exp_t sb[$];

  sevenseg_capture #(.STABLE_CYCLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .an    (an),
    .seg   (seg),
    .q3    (q3),
    .q2    (q2),
    .q1    (q1),
    .q0    (q0),
    .upd   (upd),
    .frame (frame)
`ifdef SEVENSEG_CAPTURE_ERR_EN
    ,
    .err     (err),
    .err_cnt (err_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] q_at(input int i);
    case (i)
      0:       return q0;
      1:       return q1;
      2:       return q2;
      default: return q3;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Push an expected write timed STABLE_CYCLES+1 edges after the drive point.
  task automatic expect_wr(input int idx, input logic [3:0] nib, input logic frm);
    exp_t e;
    e.idx = idx;
    e.nib = nib;
    e.frm = frm;
    e.at  = cyc + 5;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && (upd != 4'd0 || frame)) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {27'd0, upd, frame}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("upd", {28'd0, upd}, 32'd1 << e.idx);
        chk("frame", {31'd0, frame}, {31'd0, e.frm});
        chk("q_write", {28'd0, q_at(e.idx)}, {28'd0, e.nib});
        chk("latency", cyc, e.at);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    an  = 4'hF;
    seg = SEG_BLANK;
    step(3);
    chk("rst_q", {16'd0, q3, q2, q1, q0}, 32'hFFFF);
    chk("rst_upd", {28'd0, upd}, 32'd0);
    chk("rst_frame", {31'd0, frame}, 32'd0);
`ifdef SEVENSEG_CAPTURE_ERR_EN
    chk("rst_err", {23'd0, err, err_cnt}, 32'd0);
`endif
    rst = 1'b0;
    step(2);

    // Single stable digit: write exactly 5 clocks after the change, one pulse.
    an = 4'b1110; seg = SEG_3;
    expect_wr(0, 4'd3, 1'b0);
    step(10);
    chk("q0_is_3", {28'd0, q0}, 32'd3);
    chk("sb_drained_1", sb.size(), 32'd0);

    // Short run of 5 must not be accepted; 8 follows normally.
    seg = SEG_5;
    step(3);
    seg = SEG_8;
    expect_wr(0, 4'd8, 1'b0);
    step(3);
    chk("q0_not_yet_8", {28'd0, q0}, 32'd3);
    step(5);
    chk("q0_is_8", {28'd0, q0}, 32'd8);

    // Scan d0 / d1 / d0: frame only with the second digit-0 write.
    an = 4'b1110; seg = SEG_7;
    expect_wr(0, 4'd7, 1'b0);
    step(6);
    an = 4'b1101; seg = SEG_2;
    expect_wr(1, 4'd2, 1'b0);
    step(6);
    an = 4'b1110; seg = SEG_7;
    expect_wr(0, 4'd7, 1'b1);
    step(6);
    chk("scan_q1q0", {24'd0, q1, q0}, 32'h27);
    chk("sb_drained_2", sb.size(), 32'd0);

    // Malformed samples: two enables low, then invalid pattern.
    an = 4'b1100; seg = SEG_1;
    step(8);
    an = 4'b1110; seg = 7'b1010101;
    step(8);
    chk("bad_no_change", {16'd0, q3, q2, q1, q0}, 32'hFF27);
`ifdef SEVENSEG_CAPTURE_ERR_EN
    chk("err_set", {31'd0, err}, 32'd1);
    chk("err_cnt_1", {24'd0, err_cnt}, 32'd1);
    an = 4'hF; seg = SEG_BLANK;
    step(3);
    an = 4'b1011; seg = 7'b1010101;
    step(3);
    chk("err_cnt_2", {24'd0, err_cnt}, 32'd2);
`endif

    // Reset two cycles into a run of 9 on digit 1.
    an = 4'b1101; seg = SEG_9;
    step(2);
    rst = 1'b1;
    #1;
    chk("rst_mid_q1", {28'd0, q1}, 32'hF);
    chk("rst_mid_q0", {28'd0, q0}, 32'hF);
    step(2);
    rst = 1'b0;
    expect_wr(1, 4'd9, 1'b0);
    step(4);
    chk("q1_not_yet_9", {28'd0, q1}, 32'hF);
    step(1);
    chk("q1_is_9", {28'd0, q1}, 32'd9);
    step(4);
    chk("sb_drained_final", sb.size(), 32'd0);
    chk("final_q", {16'd0, q3, q2, q1, q0}, 32'hFF9F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
